// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer
// Description : Sequences one multiply or divide request at a time through
//               external multiplier/divider units. It latches operands, issues
//               a one-cycle start pulse, waits for the selected unit's ready,
//               and then presents the result for one cycle. While an operation
//               is in flight it holds the pipeline stalled. Flush aborts any
//               in-flight operation.
//               Optional WAIT timeout: define MULTDIV_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  // pipeline request
  input  logic        req_valid,
  input  logic        req_is_div,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_tag,
  input  logic        flush,
  output logic        stall,
  // unit start pulses and operands
  output logic        mult_ctrl,
  output logic        div_ctrl,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  // unit returns
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic        mult_rdy,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  input  logic        div_rdy,
  // completed result
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  result_tag,
  output logic        result_exception,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        op_div;
  logic [4:0]  lat_tag;
  logic        accept;
  logic        capture;
  logic        to_hit;
  logic        sel_rdy;
  logic [31:0] sel_result;
  logic        sel_exc;

  // Only the unit that was launched is listened to; the other is ignored.
  assign sel_rdy    = op_div ? div_rdy       : mult_rdy;
  assign sel_result = op_div ? div_result    : mult_result;
  assign sel_exc    = op_div ? div_exception : mult_exception;

  // A non-positive timeout budget cannot be honoured; this empty block just
  // anchors the parameter so both builds elaborate it identically.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_guard
  end

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             to_flag;

  // WAIT-cycle counter: cleared in LAUNCH so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == LAUNCH) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Abort on the last budgeted WAIT cycle; a ready or flush in that cycle wins.
  assign to_hit  = (state == WAIT) && !sel_rdy && !flush && (wait_cnt == CNT_LAST);
  assign timeout = (state == DONE) && to_flag;

  // Remembers whether the current DONE came from a timeout rather than a unit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_flag <= 1'b0;
    end else if (capture) begin
      to_flag <= 1'b0;
    end else if (to_hit) begin
      to_flag <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every other transition and capture.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = LAUNCH;
          accept    = 1'b1;
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (sel_rdy) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else if (to_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      capture   = 1'b0;
    end
  end

  // Request latch: operands stay frozen from LAUNCH through DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      unit_a  <= '0;
      unit_b  <= '0;
      op_div  <= 1'b0;
      lat_tag <= '0;
    end else if (accept) begin
      unit_a  <= req_a;
      unit_b  <= req_b;
      op_div  <= req_is_div;
      lat_tag <= req_tag;
    end
  end

  // Result capture: holds until the next unit return or timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result           <= '0;
      result_tag       <= '0;
      result_exception <= 1'b0;
    end else if (capture) begin
      result           <= sel_result;
      result_tag       <= lat_tag;
      result_exception <= sel_exc;
    end else if (to_hit) begin
      result           <= '0;
      result_tag       <= lat_tag;
      result_exception <= 1'b1;
    end
  end

  // Strobes decode straight from state, so reset clears them immediately.
  assign mult_ctrl    = (state == LAUNCH) && !op_div;
  assign div_ctrl     = (state == LAUNCH) &&  op_div;
  assign result_valid = (state == DONE);
  assign stall        = ((state == IDLE) && req_valid && reset_n) ||
                        (state == LAUNCH) || (state == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_sequencer
// Description : Directed self-checking bench for multdiv_sequencer. The unit
//               returns are driven by hand with known results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_is_div, flush;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_tag;
  logic        stall, mult_ctrl, div_ctrl;
  logic [31:0] unit_a, unit_b;
  logic [31:0] mult_result, div_result;
  logic        mult_exception, mult_rdy, div_exception, div_rdy;
  logic        result_valid, result_exception, timeout;
  logic [31:0] result;
  logic [4:0]  result_tag;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int mult_pulses = 0;
  int div_pulses  = 0;
  int rv_count    = 0;

  multdiv_sequencer #(.TIMEOUT_CYCLES(40)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_is_div(req_is_div), .req_a(req_a), .req_b(req_b),
    .req_tag(req_tag), .flush(flush), .stall(stall),
    .mult_ctrl(mult_ctrl), .div_ctrl(div_ctrl), .unit_a(unit_a), .unit_b(unit_b),
    .mult_result(mult_result), .mult_exception(mult_exception), .mult_rdy(mult_rdy),
    .div_result(div_result), .div_exception(div_exception), .div_rdy(div_rdy),
    .result_valid(result_valid), .result(result), .result_tag(result_tag),
    .result_exception(result_exception), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Count strobe cycles on the falling edge, away from state changes.
  always @(negedge clock) begin
    if (mult_ctrl)    mult_pulses++;
    if (div_ctrl)     div_pulses++;
    if (result_valid) rv_count++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Called on a falling edge in IDLE; returns on the falling edge in LAUNCH.
  task automatic start_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t);
    req_valid = 1'b1; req_is_div = d; req_a = a; req_b = b; req_tag = t;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Raises the selected ready n cycles after the start pulse; returns in DONE.
  task automatic finish_op(input logic d, input int n, input logic [31:0] res,
                           input logic exc);
    repeat (n) @(negedge clock);
    if (d) begin div_rdy = 1'b1;  div_result = res;  div_exception = exc;  end
    else   begin mult_rdy = 1'b1; mult_result = res; mult_exception = exc; end
    @(negedge clock);
    div_rdy = 1'b0; mult_rdy = 1'b0; div_exception = 1'b0; mult_exception = 1'b0;
  endtask

  initial begin
    int m0, d0, r0;
    reset_n = 1'b0; req_valid = 1'b0; req_is_div = 1'b0; req_a = '0; req_b = '0;
    req_tag = '0; flush = 1'b0; mult_result = '0; div_result = '0;
    mult_exception = 1'b0; div_exception = 1'b0; mult_rdy = 1'b0; div_rdy = 1'b0;

    // Reset state, including stall suppressed despite a pending request
    repeat (2) @(negedge clock);
    req_valid = 1'b1;
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_result_valid", {31'b0, result_valid}, 32'd0);
    check("rst_ctrl", {30'b0, mult_ctrl, div_ctrl}, 32'd0);
    check("rst_unit_a", unit_a, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_tag_exc_to", {25'b0, result_tag, result_exception, timeout}, 32'd0);
    req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Divide 100/7 -> 14, ready 32 cycles after the start pulse
    m0 = mult_pulses; d0 = div_pulses; r0 = rv_count;
    req_valid = 1'b1; req_is_div = 1'b1; req_a = 32'd100; req_b = 32'd7; req_tag = 5'd3;
    #1;
    check("div_stall_idle_req", {31'b0, stall}, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    check("div_launch_ctrl", {30'b0, mult_ctrl, div_ctrl}, 32'd1);
    check("div_launch_ops", {unit_a[15:0], unit_b[15:0]}, {16'd100, 16'd7});
    finish_op(1'b1, 32, 32'd14, 1'b0);
    check("div_done_rv", {31'b0, result_valid}, 32'd1);
    check("div_done_result", result, 32'd14);
    check("div_done_tag", {27'b0, result_tag}, 32'd3);
    check("div_done_exc_to", {30'b0, result_exception, timeout}, 32'd0);
    check("div_done_unit_a", unit_a, 32'd100);
    // New request arriving during DONE: no stall now, accepted in next IDLE
    req_valid = 1'b1; req_is_div = 1'b0; req_a = 32'd2; req_b = 32'd3; req_tag = 5'd1;
    #1;
    check("done_stall", {31'b0, stall}, 32'd0);
    @(negedge clock);
    check("idle_after_done_rv", {31'b0, result_valid}, 32'd0);
    check("idle_after_done_stall", {31'b0, stall}, 32'd1);
    check("idle_result_hold", result, 32'd14);
    check("div_pulse_count", div_pulses - d0, 32'd1);
    check("div_mult_pulse_count", mult_pulses - m0, 32'd0);
    check("div_rv_count", rv_count - r0, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    check("followon_launch", {30'b0, mult_ctrl, div_ctrl}, 32'd2);
    finish_op(1'b0, 1, 32'd6, 1'b0);
    check("followon_result", {result[26:0], result_tag}, {27'd6, 5'd1});
    @(negedge clock);

    // Multiply -6*5, with ready during LAUNCH and the wrong unit's ready ignored
    m0 = mult_pulses; d0 = div_pulses; r0 = rv_count;
    start_op(1'b0, 32'hFFFF_FFFA, 32'd5, 5'd9);
    mult_rdy = 1'b1; mult_result = 32'hDEAD_BEEF;
    @(negedge clock);
    mult_rdy = 1'b0; div_rdy = 1'b1; div_result = 32'h0000_0055;
    @(negedge clock);
    div_rdy = 1'b0;
    check("mul_ignore_stall", {31'b0, stall}, 32'd1);
    check("mul_ignore_rv", rv_count - r0, 32'd0);
    finish_op(1'b0, 1, 32'hFFFF_FFE2, 1'b0);
    check("mul_result", result, 32'hFFFF_FFE2);
    check("mul_tag_exc", {26'b0, result_tag, result_exception}, {26'b0, 5'd9, 1'b0});
    @(negedge clock);
    check("mul_div_ctrl_never", div_pulses - d0, 32'd0);
    check("mul_ctrl_once", mult_pulses - m0, 32'd1);

    // Divide by zero: exception passes through with a valid result
    start_op(1'b1, 32'd50, 32'd0, 5'd7);
    finish_op(1'b1, 4, 32'hFFFF_FFFF, 1'b1);
    check("dbz_rv_exc", {30'b0, result_valid, result_exception}, 32'd3);
    check("dbz_tag", {27'b0, result_tag}, 32'd7);
    @(negedge clock);
    check("dbz_exc_hold", {31'b0, result_exception}, 32'd1);

    // Flush on WAIT cycle 10 coinciding with div ready
    r0 = rv_count;
    start_op(1'b1, 32'd100, 32'd7, 5'd4);
    repeat (10) @(negedge clock);
    flush = 1'b1; div_rdy = 1'b1; div_result = 32'd99;
    @(negedge clock);
    flush = 1'b0; div_rdy = 1'b0;
    check("flush_idle_stall", {31'b0, stall}, 32'd0);
    check("flush_no_capture", result, 32'hFFFF_FFFF);
    repeat (2) @(negedge clock);
    check("flush_no_rv", rv_count - r0, 32'd0);
    start_op(1'b0, 32'd7, 32'd8, 5'd2);
    finish_op(1'b0, 2, 32'd56, 1'b0);
    check("post_flush_result", {result[26:0], result_tag}, {27'd56, 5'd2});
    check("post_flush_rv", {31'b0, result_valid}, 32'd1);
    @(negedge clock);

    // Reset mid-WAIT, then a stale div ready
    start_op(1'b1, 32'd9, 32'd9, 5'd5);
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_stall_ctrl", {29'b0, stall, mult_ctrl, div_ctrl}, 32'd0);
    check("midrst_units", unit_a | unit_b, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_misc", {25'b0, result_tag, result_exception, result_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    r0 = rv_count;
    div_rdy = 1'b1; div_result = 32'd5;
    repeat (3) @(negedge clock);
    div_rdy = 1'b0;
    check("stale_rdy_no_rv", rv_count - r0, 32'd0);
    check("stale_rdy_stall", {31'b0, stall}, 32'd0);

    // Ready withheld
    start_op(1'b1, 32'd1, 32'd1, 5'd6);
`ifdef MULTDIV_TIMEOUT_EN
    repeat (40) @(negedge clock);
    check("to_wait40_stall", {31'b0, stall}, 32'd1);
    @(negedge clock);
    check("to_done", {29'b0, result_valid, timeout, result_exception}, 32'd7);
    check("to_result", result, 32'd0);
    check("to_tag", {27'b0, result_tag}, 32'd6);
    @(negedge clock);
    check("to_cleared", {30'b0, timeout, result_valid}, 32'd0);
`else
    repeat (120) @(negedge clock);
    check("hold_stall", {31'b0, stall}, 32'd1);
    check("hold_no_timeout", {30'b0, timeout, result_valid}, 32'd0);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("hold_flush_idle", {31'b0, stall}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
